data_mem_port: RTL

DATA_MEM_PORT -- requirements
Module: data_mem_port

---
 rtl/data_mem_port.sv | 93 +++++++++
 1 files changed

// File: rtl/data_mem_port.sv
// data_mem_port: single-port word memory with byte/half/word access, fixed response latency and error reporting.
module data_mem_port #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [31:0]   mem [DEPTH];
  logic [31:0]   off, word, ld, wd;
  logic [15:0]   sh;
  logic [3:0]    be;
  logic [AW-1:0] idx;
  logic          acc, oor, mis, err;
  assign off  = req_addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign oor  = (req_addr < BASE_ADDR) || ({2'b00, off[31:2]} >= 32'(DEPTH));
  assign mis  = (req_size == 2'b01 && off[0]) || (req_size == 2'b10 && off[1:0] != 2'b00);
  assign err  = oor || mis || req_size == 2'b11;
  assign acc  = req_valid && req_ready;
  assign word = mem[idx];
  assign sh   = 16'(word >> {off[1:0], 3'b000});
  assign ld   = req_size == 2'b00 ? {{24{~req_unsigned & sh[7]}}, sh[7:0]} :
                req_size == 2'b01 ? {{16{~req_unsigned & sh[15]}}, sh[15:0]} : word;
  // Replicating store data lets the byte-enable mask alone pick the lane.
  assign wd   = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign be   = req_size == 2'b00 ? 4'b0001 << off[1:0] :
                req_size == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  always_ff @(posedge clk) begin
    if (acc && req_we && !err)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = LATENCY > 1 ? WAIT : RESP;
        cnt_d   = 3'(LATENCY - 1);
        rdata_d = (err || req_we) ? '0 : ld;
        err_d   = err;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = cnt_q == 3'd1 ? RESP : WAIT;
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid & err_q;
endmodule
